// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared CNN datapath defaults, FSM state type and the
//               ReLU/requantise helper used by the window and packer stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int RES_W_DEF = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } pack_state_e;

    // Negative results clamp to 0; positive ones shift down and saturate to PIX_W bits.
    function automatic logic [31:0] quantise(input logic signed [31:0] res,
                                             input int                 shift,
                                             input int                 pix_w);
        logic signed [31:0] v;
        logic signed [31:0] vmax;
        vmax = (32'sd1 <<< pix_w) - 32'sd1;
        v    = res >>> shift;
        if (res < 0) begin
            return '0;
        end
        if (v > vmax) begin
            return vmax;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_rd   = rd_en_i && !empty_o;
    assign w_do_wr   = wr_en_i && (!full_o || w_do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmap_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : fmap_stream_packer
// Description : Requantises conv results and re-emits the feature map as a
//               tagged raster pixel stream with valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_stream_packer
    import cnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int RES_W = RES_W_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int SHIFT = 6,
    parameter int DEPTH = 32
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic signed [RES_W-1:0] iResult,
    input  logic                    iResultValid,
    output logic        [PIX_W-1:0] oPixel,
    output logic                    oPixelValid,
    input  logic                    iPixelReady,
    output logic                    oRowLast,
    output logic                    oFrameLast,
    output logic                    oFrameDone,
    output logic                    oBusy,
    output logic                    oOverflow
);

    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int EW    = PIX_W + 2;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             qv_q;
    logic [PIX_W-1:0] qpix_q;
    logic             qrl_q;
    logic             qfl_q;
    logic             ovf_q;
    pack_state_e      state_q, state_d;

    logic             w_row_last;
    logic             w_frame_last;
    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_drop;
    logic [EW-1:0]    w_head;

    assign w_row_last   = (col_q == COL_W'(OUT_W - 1));
    assign w_frame_last = w_row_last && (row_q == ROW_W'(OUT_H - 1));
    assign w_rd         = !w_empty && iPixelReady;
    assign w_drop       = qv_q && w_full && !w_rd;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iResultValid) begin
            if (w_row_last) begin
                col_d = '0;
                row_d = w_frame_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A result landing in the same cycle as the frame-last write already
    // belongs to the next frame, so ACTIVE is kept instead of passing DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (iResultValid) state_d = ST_ACTIVE;
            ST_ACTIVE: if (qv_q && qfl_q && !iResultValid) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (iResultValid) begin
                    state_d = ST_ACTIVE;
                end else if (w_empty && !qv_q) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            col_q   <= '0;
            row_q   <= '0;
            qv_q    <= 1'b0;
            qpix_q  <= '0;
            qrl_q   <= 1'b0;
            qfl_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            qv_q    <= iResultValid;
            state_q <= state_d;
            if (iResultValid) begin
                qpix_q <= PIX_W'(quantise(32'(iResult), SHIFT, PIX_W));
                qrl_q  <= w_row_last;
                qfl_q  <= w_frame_last;
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .wr_en_i   (qv_q),
        .wr_data_i ({qfl_q, qrl_q, qpix_q}),
        .rd_en_i   (iPixelReady),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    // Head is masked while empty so stale RAM contents never reach the port.
    assign {oFrameLast, oRowLast, oPixel} = w_empty ? '0 : w_head;
    assign oPixelValid = !w_empty;
    assign oFrameDone  = w_rd && w_head[EW-1];
    assign oBusy       = (state_q != ST_IDLE) || !w_empty;
    assign oOverflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fmap_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_stream_packer
// Description : Scoreboard bench for fmap_stream_packer on a 5x5 image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_stream_packer;

    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int RES_W = 20;
    localparam int PIX_W = 8;
    localparam int SHIFT = 6;
    localparam int DEPTH = 8;
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;

    logic                    iClk = 1'b0;
    logic                    iRst = 1'b1;
    logic signed [RES_W-1:0] iResult = '0;
    logic                    iResultValid = 1'b0;
    logic                    iPixelReady = 1'b0;
    logic        [PIX_W-1:0] oPixel;
    logic                    oPixelValid;
    logic                    oRowLast;
    logic                    oFrameLast;
    logic                    oFrameDone;
    logic                    oBusy;
    logic                    oOverflow;

    typedef struct packed {
        logic             fl;
        logic             rl;
        logic [PIX_W-1:0] pix;
    } exp_t;

    exp_t sbq[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   done_cnt     = 0;
    int   m_col        = 0;
    int   m_row        = 0;

    fmap_stream_packer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RES_W (RES_W),
        .PIX_W (PIX_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iResult      (iResult),
        .iResultValid (iResultValid),
        .oPixel       (oPixel),
        .oPixelValid  (oPixelValid),
        .iPixelReady  (iPixelReady),
        .oRowLast     (oRowLast),
        .oFrameLast   (oFrameLast),
        .oFrameDone   (oFrameDone),
        .oBusy        (oBusy),
        .oOverflow    (oOverflow)
    );

    always #5 iClk = ~iClk;

    function automatic logic [PIX_W-1:0] model_q(input int r);
        int v;
        if (r < 0) return '0;
        v = r / (1 << SHIFT);
        if (v > 255) return 8'd255;
        return PIX_W'(v);
    endfunction

    // One clock: sample at the falling edge, pop the scoreboard on a handshake.
    task automatic step();
        exp_t e;
        @(negedge iClk);
        if (oPixelValid && iPixelReady) begin
            tests_run++;
            if (sbq.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_extra: got pix=%0d rl=%b fl=%b, no entry expected", oPixel, oRowLast, oFrameLast);
            end else begin
                e = sbq.pop_front();
                if ({oFrameDone, oFrameLast, oRowLast, oPixel} !== {e.fl, e.fl, e.rl, e.pix}) begin
                    tests_failed++;
                    $display("FAIL sb_pixel: got done=%b fl=%b rl=%b pix=%0d, need done=%b fl=%b rl=%b pix=%0d",
                             oFrameDone, oFrameLast, oRowLast, oPixel, e.fl, e.fl, e.rl, e.pix);
                end
            end
        end
        if (oFrameDone === 1'b1) done_cnt++;
        @(posedge iClk);
        #1;
    endtask

    task automatic send(input int r, input bit keep);
        exp_t e;
        e.pix = model_q(r);
        e.rl  = (m_col == OUT_W - 1);
        e.fl  = e.rl && (m_row == OUT_H - 1);
        if (keep) sbq.push_back(e);
        if (e.rl) begin
            m_col = 0;
            m_row = e.fl ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        iResult      = RES_W'(r);
        iResultValid = 1'b1;
        step();
        iResultValid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((sbq.size() != 0 || oPixelValid) && n < max_cyc) begin
            step();
            n++;
        end
        tests_run++;
        if (sbq.size() != 0 || oPixelValid) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, valid=%b after %0d cycles, need 0 and 0", sbq.size(), oPixelValid, n);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        tests_run++;
        if ({oPixel, oPixelValid, oRowLast, oFrameLast, oFrameDone, oBusy, oOverflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pix=%0d v=%b rl=%b fl=%b fd=%b busy=%b ovf=%b, need all 0",
                     oPixel, oPixelValid, oRowLast, oFrameLast, oFrameDone, oBusy, oOverflow);
        end
        iRst = 1'b0;
        step();
        tests_run++;
        if (oBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_busy: got %b, need 0", oBusy);
        end
    endtask

    task automatic test_small_frame();
        int d0;
        iPixelReady = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) send(i << SHIFT, 1'b1);
        step();
        step();
        tests_run++;
        if (done_cnt !== d0 + 1) begin
            tests_failed++;
            $display("FAIL frame_done: got %0d pulses, need 1", done_cnt - d0);
        end
        tests_run++;
        if (oBusy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_hold: got %b, need 1", oBusy);
        end
        step();
        tests_run++;
        if (oBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_drop: got %b, need 0", oBusy);
        end
        drain(4);
    endtask

    task automatic test_quantise();
        iPixelReady = 1'b1;
        send(-1, 1'b1);
        tests_run++;
        if (oPixelValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_1: valid got %b, need 0", oPixelValid);
        end
        step();
        tests_run++;
        if (oPixelValid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_2: valid got %b, need 1", oPixelValid);
        end
        send(32'h7FFFF, 1'b1);
        send(100 << SHIFT, 1'b1);
        send((100 << SHIFT) + 63, 1'b1);
        for (int i = 0; i < 5; i++) send((i * 50 + 7) << SHIFT, 1'b1);
        drain(12);
    endtask

    task automatic test_full_rw();
        iPixelReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) send((i * 20 + 3) << SHIFT, 1'b1);
        step();
        step();
        send(200 << SHIFT, 1'b1);
        iPixelReady = 1'b1;
        step();
        iPixelReady = 1'b0;
        step();
        tests_run++;
        if (oOverflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_rw_no_drop: overflow got %b, need 0", oOverflow);
        end
        tests_run++;
        if (oPixel !== sbq[0].pix) begin
            tests_failed++;
            $display("FAIL hold_stable: pix got %0d, need %0d", oPixel, sbq[0].pix);
        end
        iPixelReady = 1'b1;
        drain(DEPTH + 8);
    endtask

    task automatic test_overflow();
        iPixelReady = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) send((i * 9 + 1) << SHIFT, (i < DEPTH));
        step();
        step();
        tests_run++;
        if (oOverflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_set: got %b, need 1", oOverflow);
        end
        tests_run++;
        if ({oRowLast, oPixel} !== {sbq[0].rl, sbq[0].pix}) begin
            tests_failed++;
            $display("FAIL stall_head: got rl=%b pix=%0d, need rl=%b pix=%0d", oRowLast, oPixel, sbq[0].rl, sbq[0].pix);
        end
        iPixelReady = 1'b1;
        drain(DEPTH + 8);
        for (int i = 0; i < 7; i++) send((i * 31) << SHIFT, 1'b1);
        drain(12);
        tests_run++;
        if (oOverflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got %b, need 1", oOverflow);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        iPixelReady = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 18; i++) send((((i * 37) % 256) << SHIFT) + (i % 64), 1'b1);
        drain(12);
        tests_run++;
        if (done_cnt !== d0 + 2) begin
            tests_failed++;
            $display("FAIL two_frame_done: got %0d pulses, need 2", done_cnt - d0);
        end
        repeat (3) step();
        tests_run++;
        if (oBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy got %b, need 0", oBusy);
        end
    endtask

    task automatic test_reset_mid();
        iPixelReady = 1'b0;
        for (int i = 0; i < 5; i++) send((i + 40) << SHIFT, 1'b1);
        step();
        step();
        tests_run++;
        if (oPixelValid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_valid: got %b, need 1", oPixelValid);
        end
        #2;
        iRst = 1'b1;
        #1;
        tests_run++;
        if ({oPixel, oPixelValid, oRowLast, oFrameLast, oFrameDone, oBusy, oOverflow} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got pix=%0d v=%b rl=%b fl=%b fd=%b busy=%b ovf=%b, need all 0",
                     oPixel, oPixelValid, oRowLast, oFrameLast, oFrameDone, oBusy, oOverflow);
        end
        sbq.delete();
        m_col = 0;
        m_row = 0;
        step();
        iRst = 1'b0;
        iPixelReady = 1'b1;
        for (int i = 0; i < 3; i++) send((i + 60) << SHIFT, 1'b1);
        drain(10);
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_quantise();
        test_full_rw();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
